forward_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipelined CPU. Tracks in-flight register writes
//  in a STAGES-deep shadow pipeline. For every decode-stage read port it generates a bypass select,

---
 rtl/forward_scoreboard.sv | 119 +++++++++++
 tb/tb_forward_scoreboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Purpose: operand-forwarding and load-use hazard unit that sits beside the decode/execute boundary.
// Latency: fwd_sel and stall are combinational (0 cycles); the producer shadow pipeline advances every clock.
// Backpressure: stall holds fetch/decode for one cycle per load-use pair and injects a bubble into stage 1.
//
// Optional feature: define FWD_STALL_COUNT_EN to add a saturating 16-bit stall_cnt output.

module forward_scoreboard #(
    parameter int NUM_READ = 2,
    parameter int STAGES   = 2,   // tracked producer stages after issue; must be >= 2
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic                      issue_we,
    input  logic                      issue_load,
    input  logic [NUM_READ*REG_W-1:0] src_addr,
    input  logic [NUM_READ-1:0]       src_used,
    output logic [NUM_READ*SW-1:0]    fwd_sel,
    output logic                      stall
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);

    // One tracked producer: where its result is headed and whether it is usable for bypass.
    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
    } stage_t;

    // Index k matches the bypass select encoding: stage 1 is EX, stage 2 is MEM, and so on.
    stage_t           stg [1:STAGES];
    stage_t           stg_in;
    logic [STAGES:1]  match [NUM_READ];

    // Per-port, per-stage producer match; the zero register and unused ports never match.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            match[i] = '0;
            for (int k = 1; k <= STAGES; k++) begin
                match[i][k] = stg[k].vld && stg[k].we
                           && (stg[k].rd == src_addr[i*REG_W +: REG_W])
                           && src_used[i]
                           && (src_addr[i*REG_W +: REG_W] != ZERO_ADDR);
            end
        end
    end

    // Bypass select: scan oldest to youngest so the youngest matching producer is written last and wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (match[i][k]) begin
                    fwd_sel[i*SW +: SW] = SW'(k);
                end
            end
        end
    end

    // Load-use hazard: a load still in stage 1 has no result yet, so any consumer of it must wait a cycle.
    // A load that has reached stage 2 or beyond forwards normally.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (match[i][1] && stg[1].load) begin
                stall = 1'b1;
            end
        end
    end

    // Entry into stage 1: a stalled or flushed issue becomes a bubble; upstream re-presents it.
    always_comb begin
        stg_in      = '0;
        stg_in.vld  = issue_valid && !stall && !flush;
        stg_in.rd   = issue_rd;
        stg_in.we   = issue_we;
        stg_in.load = issue_load;
    end

    // Shadow pipeline: advances every clock with no enable; flush clears every valid bit at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                stg[k] <= '0;
            end
        end else begin
            stg[1] <= stg_in;
            for (int k = 2; k <= STAGES; k++) begin
                stg[k] <= '{vld:  stg[k-1].vld && !flush,
                            rd:   stg[k-1].rd,
                            we:   stg[k-1].we,
                            load: stg[k-1].load};
            end
        end
    end

`ifdef FWD_STALL_COUNT_EN
    // Saturating count of load-use stall cycles; a stall coinciding with a flush is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Purpose: directed-vector bench for forward_scoreboard with a queue-based scoreboard.
// Latency: each vector is driven just after a rising edge and its expectation is checked at the next falling edge.
// Backpressure: none; the driver issues one vector per clock and the monitor drains one expectation per clock.

module tb_forward_scoreboard;

    localparam int NR = 2;
    localparam int ST = 3;
    localparam int RW = 5;
    localparam int SW = 2;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               flush       = 1'b0;
    logic               issue_valid = 1'b0;
    logic [RW-1:0]      issue_rd    = '0;
    logic               issue_we    = 1'b0;
    logic               issue_load  = 1'b0;
    logic [NR*RW-1:0]   src_addr    = '0;
    logic [NR-1:0]      src_used    = '0;
    logic [NR*SW-1:0]   fwd_sel;
    logic               stall;
`ifdef FWD_STALL_COUNT_EN
    logic [15:0]        stall_cnt;
`endif

    forward_scoreboard #(
        .NUM_READ (NR),
        .STAGES   (ST),
        .REG_W    (RW),
        .ZERO_REG (31)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_we    (issue_we),
        .issue_load  (issue_load),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef FWD_STALL_COUNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected response for one cycle; -1 marks a don't-care field.
    typedef struct {
        int e0;
        int e1;
        int est;
        int ecnt;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string nm, input string what, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s %s: got %0d, expected %0d", nm, what, act, req);
        end
    endtask

    // Drive one vector just after the rising edge, optionally change reset, and queue its expectation.
    task automatic cyc(input logic iv, input logic [RW-1:0] rd, input logic we, input logic ld,
                       input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [1:0] used,
                       input logic fl, input int e0, input int e1, input int est,
                       input string nm, input logic rv = 1'b1, input int ecnt = -1);
        @(posedge clk);
        #1;
        issue_valid = iv;
        issue_rd    = rd;
        issue_we    = we;
        issue_load  = ld;
        src_addr    = {s1, s0};
        src_used    = used;
        flush       = fl;
        #1;
        rst_n       = rv;
        exp_q.push_back('{e0, e1, est, ecnt});
        name_q.push_back(nm);
    endtask

    // Monitor: on every falling edge, pop and compare the expectation queued for this cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.e0 >= 0)  chk(nm, "fwd_sel0", int'(fwd_sel[1:0]), e.e0);
                if (e.e1 >= 0)  chk(nm, "fwd_sel1", int'(fwd_sel[3:2]), e.e1);
                if (e.est >= 0) chk(nm, "stall", int'(stall), e.est);
`ifdef FWD_STALL_COUNT_EN
                if (e.ecnt >= 0) chk(nm, "stall_cnt", int'(stall_cnt), e.ecnt);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with random inputs, then released with nothing issued.
        repeat (3) cyc(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom),
                       0, 0, 0, "reset", 1'b0, 0);
        repeat (3) cyc(1'b0, 5'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom), 5'($urandom), 2'b11, 1'b0,
                       0, 0, 0, "post_reset", 1'b1, 0);

        // ALU chain through stages 1, 2, 3 and out.
        cyc(1, 3,  1, 0,  0,  0, 2'b00, 0,  0, 0, 0, "alu_issue");
        cyc(1, 10, 1, 0,  3,  0, 2'b01, 0,  1, 0, 0, "alu_fwd1");
        cyc(0, 0,  0, 0,  3,  0, 2'b01, 0,  2, 0, 0, "alu_fwd2");
        cyc(0, 0,  0, 0,  3, 10, 2'b11, 0,  3, 2, 0, "alu_fwd3");
        cyc(0, 0,  0, 0,  3, 10, 2'b11, 0,  0, 3, 0, "alu_retired");

        // Youngest producer wins; non-writing producers are ignored.
        cyc(1, 5, 1, 0,  0, 0, 2'b00, 0,  0, 0, 0, "pri_a");
        cyc(1, 5, 1, 0,  0, 0, 2'b00, 0,  0, 0, 0, "pri_b");
        cyc(0, 0, 0, 0,  0, 5, 2'b10, 0,  0, 1, 0, "pri_young");
        cyc(0, 0, 0, 0,  0, 5, 2'b10, 0,  0, 2, 0, "pri_older");
        cyc(1, 6, 0, 0,  0, 0, 2'b00, 0,  0, 0, 0, "nowe_issue");
        cyc(0, 0, 0, 0,  6, 0, 2'b01, 0,  0, 0, 0, "nowe_read");

        // Load-use on port 1: one stall, bubble in stage 1, then forward from the load in stage 2.
        cyc(1, 7,  1, 1,  0,  0, 2'b00, 0,  0,  0, 0, "lu_issue");
        cyc(1, 12, 1, 0, 12,  7, 2'b10, 0,  0, -1, 1, "lu_stall");
        cyc(1, 12, 1, 0, 12,  7, 2'b11, 0,  0,  2, 0, "lu_bubble");
        cyc(0, 0,  0, 0, 12,  7, 2'b11, 0,  1,  3, 0, "lu_after");

        // Load-use on port 0.
        cyc(1, 8, 1, 1,  0, 0, 2'b00, 0,  0, 0, 0, "lu0_issue");
        cyc(0, 0, 0, 0,  8, 0, 2'b01, 0, -1, 0, 1, "lu0_stall");
        cyc(0, 0, 0, 0,  8, 8, 2'b11, 0,  2, 2, 0, "lu0_fwd");

        // Zero register never forwards or stalls; unused ports never match.
        cyc(1, 31, 1, 0,  0,  0, 2'b00, 0,  0, 0, 0, "zero_issue");
        cyc(1, 31, 1, 1, 31, 31, 2'b11, 0,  0, 0, 0, "zero_fwd");
        cyc(0, 0,  0, 0, 31, 31, 2'b11, 0,  0, 0, 0, "zero_load");
        cyc(1, 4,  1, 1,  0,  0, 2'b00, 0,  0, 0, 0, "unused_issue");
        cyc(0, 0,  0, 0,  4,  9, 2'b10, 0,  0, 0, 0, "unused_read");

        // Asynchronous reset mid-operation clears outputs before the next edge.
        cyc(1, 7, 1, 1,  0, 0, 2'b00, 0,  0, 0, 0, "ar_issue");
        cyc(0, 0, 0, 0,  7, 0, 2'b01, 0, -1, 0, 1, "ar_stall",   1'b1, 2);
        cyc(0, 0, 0, 0,  7, 0, 2'b01, 0,  0, 0, 0, "ar_reset",   1'b0, 0);
        cyc(0, 0, 0, 0,  7, 0, 2'b01, 0,  0, 0, 0, "ar_release", 1'b1, 0);

        // Flush kills tracked entries and a same-cycle issue; a flushed stall is not counted.
        cyc(1, 9,  1, 1,  0,  0, 2'b00, 0,  0, 0, 0, "fl_issue");
        cyc(0, 0,  0, 0,  9,  0, 2'b01, 1, -1, 0, 1, "fl_stall");
        cyc(0, 0,  0, 0,  9,  9, 2'b11, 0,  0, 0, 0, "fl_cleared");
        cyc(1, 14, 1, 0,  0,  0, 2'b00, 1,  0, 0, 0, "fl_issue_kill");
        cyc(0, 0,  0, 0, 14,  0, 2'b01, 0,  0, 0, 0, "fl_kill_read");
        cyc(1, 15, 1, 0,  0,  0, 2'b00, 0,  0, 0, 0, "fl_old_issue");
        cyc(0, 0,  0, 0,  0,  0, 2'b00, 0,  0, 0, 0, "fl_old_idle");
        cyc(0, 0,  0, 0,  0, 15, 2'b10, 1,  0, 2, 0, "fl_old_pre");
        cyc(0, 0,  0, 0,  0, 15, 2'b10, 0,  0, 0, 0, "fl_old_post", 1'b1, 0);

        // Three counted load-use stalls.
        for (int n = 0; n < 3; n++) begin
            cyc(1, 20, 1, 1,  0,  0, 2'b00, 0,  0,  0, 0, "sc_issue");
            cyc(0, 0,  0, 0,  0, 20, 2'b10, 0,  0, -1, 1, "sc_stall");
        end
        cyc(0, 0, 0, 0,  0, 20, 2'b10, 0,  0, 2, 0, "sc_final", 1'b1, 3);

        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
